// File: rtl/uart_pkg.sv
// Shared UART definitions: frame constants, transmitter state encoding and the
// parity helper used by both directions of the peripheral.
package uart_pkg;

    localparam int   UART_DATA_BITS = 8;
    localparam logic UART_LINE_IDLE = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_tx_state_t;

    // odd=0 gives the even-parity bit, odd=1 the odd-parity bit
    function automatic logic uart_parity(input logic [UART_DATA_BITS-1:0] data,
                                         input logic                      odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_baud_timer.sv
// Reloadable bit-period down-counter; tick marks the last cycle of a bit while
// the owning engine is active. Shared between the UART transmitter and receiver.
module uart_baud_timer #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 g_clk,
    input  logic                 g_resetn,
    input  logic                 active_i,
    input  logic                 load_i,
    input  logic [DIV_WIDTH-1:0] load_val_i,
    output logic                 tick_o
);

    logic [DIV_WIDTH-1:0] cnt_q;

    // Count down to zero and hold; a load restarts the bit period
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            cnt_q <= {DIV_WIDTH{1'b0}};
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != {DIV_WIDTH{1'b0}}) begin
            cnt_q <= cnt_q - DIV_WIDTH'(1);
        end else begin
            cnt_q <= cnt_q;
        end
    end

    assign tick_o = active_i && (cnt_q == {DIV_WIDTH{1'b0}});

endmodule

// File: rtl/uart_tx.sv
// UART transmit engine: pops bytes from the TX FIFO and serialises them as
// start, LSB-first data, optional parity and one or two stop bits.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DIV_WIDTH = 16,
    parameter int DATA_BITS = UART_DATA_BITS
) (
    input  logic                 g_clk,
    input  logic                 g_resetn,
    output logic                 g_clk_req,
    input  logic                 cfg_en,
    input  logic [DIV_WIDTH-1:0] cfg_clk_div,
    input  logic                 cfg_parity_en,
    input  logic                 cfg_parity_odd,
    input  logic                 cfg_stop2,
    input  logic                 fifo_valid,
    input  logic [DATA_BITS-1:0] fifo_data,
    output logic                 fifo_pop,
    output logic                 uart_txd,
    output logic                 busy
);

    localparam int                BIT_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(DATA_BITS - 1);

    uart_tx_state_t       state_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [BIT_W-1:0]     bit_cnt_q;
    logic                 stop_cnt_q;
    logic [DIV_WIDTH-1:0] div_q;
    logic                 parity_en_q;
    logic                 parity_bit_q;
    logic                 stop2_q;
    logic                 txd_q;
    logic                 busy_q;

    logic                 tick_s;
    logic                 last_stop_s;
    logic                 pop_s;
    logic                 load_s;
    logic [DIV_WIDTH-1:0] load_val_s;

    // Reloading on every tick restarts the period for whichever bit comes next;
    // a pop must use the live divider since the latched one belongs to the old frame.
    assign last_stop_s = (state_q == STOP) && tick_s && (!stop2_q || stop_cnt_q);
    assign pop_s       = cfg_en && fifo_valid && g_resetn &&
                         ((state_q == IDLE) || last_stop_s);
    assign load_s      = pop_s || tick_s;
    assign load_val_s  = pop_s ? cfg_clk_div : div_q;

    uart_baud_timer #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_baud_timer (
        .g_clk      (g_clk),
        .g_resetn   (g_resetn),
        .active_i   (state_q != IDLE),
        .load_i     (load_s),
        .load_val_i (load_val_s),
        .tick_o     (tick_s)
    );

    // Frame sequencer; line level and busy are registered alongside the state
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            state_q      <= IDLE;
            shift_q      <= {DATA_BITS{1'b0}};
            bit_cnt_q    <= {BIT_W{1'b0}};
            stop_cnt_q   <= 1'b0;
            div_q        <= {DIV_WIDTH{1'b0}};
            parity_en_q  <= 1'b0;
            parity_bit_q <= 1'b0;
            stop2_q      <= 1'b0;
            txd_q        <= UART_LINE_IDLE;
            busy_q       <= 1'b0;
        end else if (pop_s) begin
            state_q      <= START;
            shift_q      <= fifo_data;
            bit_cnt_q    <= {BIT_W{1'b0}};
            stop_cnt_q   <= 1'b0;
            div_q        <= cfg_clk_div;
            parity_en_q  <= cfg_parity_en;
            parity_bit_q <= uart_parity(fifo_data, cfg_parity_odd);
            stop2_q      <= cfg_stop2;
            txd_q        <= 1'b0;
            busy_q       <= 1'b1;
        end else if (tick_s) begin
            case (state_q)
                START: begin
                    state_q   <= DATA;
                    txd_q     <= shift_q[0];
                    shift_q   <= {1'b0, shift_q[DATA_BITS-1:1]};
                    bit_cnt_q <= {BIT_W{1'b0}};
                end
                DATA: begin
                    if (bit_cnt_q == LAST_BIT) begin
                        if (parity_en_q) begin
                            state_q <= PARITY;
                            txd_q   <= parity_bit_q;
                        end else begin
                            state_q    <= STOP;
                            txd_q      <= UART_LINE_IDLE;
                            stop_cnt_q <= 1'b0;
                        end
                    end else begin
                        txd_q     <= shift_q[0];
                        shift_q   <= {1'b0, shift_q[DATA_BITS-1:1]};
                        bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                    end
                end
                PARITY: begin
                    state_q    <= STOP;
                    txd_q      <= UART_LINE_IDLE;
                    stop_cnt_q <= 1'b0;
                end
                STOP: begin
                    // A follow-on pop at the final stop tick is taken by the pop branch
                    if (stop2_q && !stop_cnt_q) begin
                        stop_cnt_q <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                    txd_q <= UART_LINE_IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    txd_q   <= UART_LINE_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end else begin
            state_q <= state_q;
        end
    end

    assign fifo_pop  = pop_s;
    assign uart_txd  = txd_q;
    assign busy      = busy_q;
    assign g_clk_req = busy_q || (cfg_en && fifo_valid);

endmodule

// File: tb/tb_uart_tx.sv
// Randomised bench for uart_tx: a line-level reference model predicts every
// cycle of uart_txd, busy, g_clk_req and fifo_pop from the frame rules.
module tb_uart_tx;

    localparam int DW = 16;
    localparam int DB = 8;

    logic          g_clk = 1'b0;
    logic          g_resetn = 1'b0;
    logic          g_clk_req;
    logic          cfg_en = 1'b0;
    logic [DW-1:0] cfg_clk_div = '0;
    logic          cfg_parity_en = 1'b0;
    logic          cfg_parity_odd = 1'b0;
    logic          cfg_stop2 = 1'b0;
    logic          fifo_valid = 1'b0;
    logic [DB-1:0] fifo_data = '0;
    logic          fifo_pop;
    logic          uart_txd;
    logic          busy;

    int         checks_n = 0;
    int         errors_n = 0;
    int         cyc_n = 0;
    int         busy_cycles = 0;
    int         pop_count = 0;
    bit         pop_pending = 1'b0;
    logic [7:0] fifo_q[$];
    logic       exp_q[$];
    logic       line_log[$];
    int         pop_times[$];

    uart_tx #(.DIV_WIDTH(DW), .DATA_BITS(DB)) dut (
        .g_clk          (g_clk),
        .g_resetn       (g_resetn),
        .g_clk_req      (g_clk_req),
        .cfg_en         (cfg_en),
        .cfg_clk_div    (cfg_clk_div),
        .cfg_parity_en  (cfg_parity_en),
        .cfg_parity_odd (cfg_parity_odd),
        .cfg_stop2      (cfg_stop2),
        .fifo_valid     (fifo_valid),
        .fifo_data      (fifo_data),
        .fifo_pop       (fifo_pop),
        .uart_txd       (uart_txd),
        .busy           (busy)
    );

    always #5 g_clk = ~g_clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_n++;
        if (obs !== exp) begin
            errors_n++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc_n, obs, exp);
        end
    endtask

    // Line levels of one whole frame, one entry per clock cycle
    task automatic build_frame(input logic [7:0] d);
        logic bits[$];
        logic p;
        int   reps;
        reps = int'(cfg_clk_div) + 1;
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (cfg_parity_en) begin
            p = (($countones(d) % 2) == 1) ? 1'b1 : 1'b0;
            bits.push_back(p ^ cfg_parity_odd);
        end
        bits.push_back(1'b1);
        if (cfg_stop2) bits.push_back(1'b1);
        foreach (bits[i]) repeat (reps) exp_q.push_back(bits[i]);
    endtask

    task automatic model_step();
        logic cur;
        logic frame;
        logic exp_pop;
        frame = (exp_q.size() != 0);
        cur   = frame ? exp_q.pop_front() : 1'b1;
        chk("txd", uart_txd, cur);
        chk("busy", busy, frame);
        chk("clk_req", g_clk_req, frame || (cfg_en && fifo_valid));
        exp_pop = cfg_en && fifo_valid && g_resetn && (exp_q.size() == 0);
        chk("pop", fifo_pop, exp_pop);
        line_log.push_back(uart_txd);
        if (busy === 1'b1) busy_cycles++;
        if (fifo_pop === 1'b1) begin
            pop_count++;
            pop_times.push_back(cyc_n);
        end
        if (!g_resetn) begin
            exp_q.delete();
        end else if (exp_pop) begin
            build_frame(fifo_q[0]);
            pop_pending = 1'b1;
        end
        cyc_n++;
    endtask

    task automatic refresh();
        fifo_valid = (fifo_q.size() != 0);
        fifo_data  = fifo_valid ? fifo_q[0] : 8'($urandom);
    endtask

    task automatic cycle();
        logic [7:0] tmp;
        @(negedge g_clk);
        model_step();
        @(posedge g_clk);
        #1;
        if (pop_pending) begin
            tmp = fifo_q.pop_front();
            pop_pending = 1'b0;
        end
        refresh();
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic push(input logic [7:0] d);
        fifo_q.push_back(d);
        refresh();
    endtask

    task automatic clear_stats();
        line_log.delete();
        pop_times.delete();
        busy_cycles = 0;
        pop_count   = 0;
    endtask

    task automatic wait_idle(input int budget);
        int i;
        i = 0;
        while ((exp_q.size() != 0 || (cfg_en && fifo_q.size() != 0)) && i < budget) begin
            cycle();
            i++;
        end
        chk("drain", exp_q.size() + (cfg_en ? fifo_q.size() : 0), 0);
        run(2);
    endtask

    task automatic set_cfg(input int div, input logic pe, input logic po, input logic s2);
        cfg_clk_div    = DW'(div);
        cfg_parity_en  = pe;
        cfg_parity_odd = po;
        cfg_stop2      = s2;
    endtask

    initial begin
        logic [9:0] pat;
        int         s;

        // Reset state
        @(posedge g_clk);
        #1;
        run(3);
        g_resetn = 1'b1;
        run(2);

        // Basic frame 0xA5, div=3
        set_cfg(3, 1'b0, 1'b0, 1'b0);
        cfg_en = 1'b1;
        clear_stats();
        push(8'hA5);
        run(50);
        chk("basic_pops", pop_count, 1);
        chk("basic_busy", busy_cycles, 40);
        pat = 10'b1101001010;
        s = -1;
        foreach (line_log[i]) if (s < 0 && line_log[i] == 1'b0) s = i;
        chk("basic_start_found", (s >= 0) ? 1 : 0, 1);
        if (s < 0) s = 0;
        for (int b = 0; b < 10; b++) chk("basic_bit", line_log[s + 4*b + 2], pat[b]);

        // Parity variants
        set_cfg(3, 1'b1, 1'b0, 1'b0); push(8'hA5); wait_idle(200);
        set_cfg(3, 1'b1, 1'b1, 1'b0); push(8'hA5); wait_idle(200);
        set_cfg(3, 1'b1, 1'b0, 1'b0); push(8'h07); wait_idle(200);
        clear_stats();
        set_cfg(3, 1'b1, 1'b1, 1'b1); push(8'hA5); wait_idle(200);
        chk("par_stop2_len", busy_cycles, 48);

        // Back-to-back at div=0
        cfg_en = 1'b0;
        set_cfg(0, 1'b0, 1'b0, 1'b0);
        push(8'h55); push(8'h0F);
        run(3);
        clear_stats();
        cfg_en = 1'b1;
        wait_idle(100);
        chk("b2b_pops", pop_count, 2);
        if (pop_times.size() == 2) chk("b2b_gap", pop_times[1] - pop_times[0], 10);
        chk("b2b_busy", busy_cycles, 20);

        // Enable gating
        cfg_en = 1'b0;
        clear_stats();
        push(8'h3C);
        run(10);
        chk("gate_nopop", pop_count, 0);
        cfg_en = 1'b1;
        wait_idle(100);
        chk("gate_sent", pop_count, 1);
        clear_stats();
        set_cfg(3, 1'b0, 1'b0, 1'b0);
        push(8'h81); push(8'h42);
        run(5);
        cfg_en = 1'b0;
        run(60);
        chk("gate_drop_pops", pop_count, 1);
        cfg_en = 1'b1;
        wait_idle(200);

        // Reset during DATA
        set_cfg(7, 1'b0, 1'b0, 1'b0);
        clear_stats();
        push(8'hC3); push(8'h96);
        run(33);
        g_resetn = 1'b0;
        run(2);
        g_resetn = 1'b1;
        wait_idle(300);
        chk("rst_pops", pop_count, 2);

        // Divider change mid-frame
        set_cfg(3, 1'b0, 1'b0, 1'b0);
        clear_stats();
        push(8'h5A); push(8'hE1);
        run(6);
        cfg_clk_div = DW'(1);
        wait_idle(200);
        if (pop_times.size() == 2) chk("latch_gap", pop_times[1] - pop_times[0], 40);
        chk("latch_busy", busy_cycles, 60);

        // Randomised traffic with mid-frame config churn, enable drops and resets
        for (int it = 0; it < 40; it++) begin
            set_cfg($urandom_range(0, 5), 1'($urandom), 1'($urandom), 1'($urandom));
            cfg_en = 1'b1;
            repeat ($urandom_range(1, 3)) push(8'($urandom));
            run($urandom_range(0, 30));
            set_cfg($urandom_range(0, 5), 1'($urandom), 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                cfg_en = 1'b0;
                run($urandom_range(1, 20));
                cfg_en = 1'b1;
            end
            if ($urandom_range(0, 7) == 0) begin
                g_resetn = 1'b0;
                run(1);
                g_resetn = 1'b1;
            end
            wait_idle(2000);
        end

        $display("CHECKS %0d ERRORS %0d", checks_n, errors_n);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial transmit engine for the UART peripheral; drains the TX uart_fifo through its valid/data/pop read port.
- Serialises each byte onto uart_txd as: start bit, LSB-first data, optional parity, 1 or 2 stop bits.
- Bit timing comes from a programmable clock divider. Frame configuration is latched per byte at pop time.

Parameters:
- DIV_WIDTH, 16, width of the clock divider configuration.
- DATA_BITS, 8, data bits per frame; must equal the TX FIFO WIDTH.

Ports:
- g_clk  input  1  clock.
- g_resetn  input  1  reset.
- g_clk_req  output  1  clock request; high while busy or a byte is pending and cfg_en=1.
- cfg_en  input  1  transmitter enable; gates new pops only.
- cfg_clk_div  input  DIV_WIDTH  bit period minus one, in g_clk cycles.
- cfg_parity_en  input  1  append parity bit.
- cfg_parity_odd  input  1  1 = odd parity, 0 = even parity.
- cfg_stop2  input  1  1 = two stop bits, 0 = one stop bit.
- fifo_valid  input  1  TX FIFO head valid.
- fifo_data  input  DATA_BITS  TX FIFO head data.
- fifo_pop  output  1  pop TX FIFO head this cycle.
- uart_txd  output  1  serial line, idle high.
- busy  output  1  frame in progress.

Behaviour:
- Clock and reset: clock g_clk; reset g_resetn, synchronous, active-low.
- Reset values: uart_txd=1, busy=0, state=IDLE, counters 0. fifo_pop is forced 0 while g_resetn=0.
- States: IDLE, START, DATA, PARITY, STOP.
- Bit period is (latched_div+1) cycles. A down-counter loads latched_div at each bit start; tick = counter==0 while not IDLE.
- Pop condition: cfg_en && fifo_valid && g_resetn && (IDLE, or STOP on the tick of its final stop bit). fifo_pop is combinational from this condition.
- Same-cycle FIFO handshake: data is accepted in the cycle fifo_pop is high.
- On pop:
  - Capture fifo_data into the shift register.
  - Latch cfg_clk_div, cfg_parity_en, cfg_parity_odd and cfg_stop2.
  - Precompute parity = ^data ^ parity_odd.
  - Next state START; uart_txd=0 from the next cycle.
- uart_txd is registered and driven per state:
  - START: 0.
  - DATA: shift_reg[0], shifted right on each tick.
  - PARITY: parity bit.
  - STOP and IDLE: 1.
- Transitions, each taken on tick:
  - START -> DATA.
  - DATA -> DATA until DATA_BITS bits have been sent (bit counter wraps at DATA_BITS-1).
  - Then -> PARITY if latched parity_en, else -> STOP.
  - PARITY -> STOP.
  - STOP holds for 1 or 2 bit periods, then -> START if the pop condition holds, else -> IDLE.
- Back-to-back frames: zero idle cycles between the last stop bit and the next start bit.
- Frame length: (1+DATA_BITS+parity+stop)*(div+1) cycles.
- busy = state != IDLE.
- cfg_en deasserted mid-frame: the current frame completes normally; no further pop.
- Config changes mid-frame: no effect until the next pop.
- fifo_valid dropping mid-frame: no effect.
- Reset mid-frame:
  - Frame aborted; uart_txd=1 on the next edge.
  - No byte is popped while in reset.
- cfg_clk_div=0 is legal: one cycle per bit.
- Counter widths: DIV_WIDTH for the bit timer; clog2(DATA_BITS) for the bit counter; 1 bit for the stop counter.

Decomposition:
- uart_pkg holds:
  - UART_DATA_BITS=8 and UART_LINE_IDLE=1'b1.
  - typedef enum uart_tx_state_t {IDLE, START, DATA, PARITY, STOP}.
  - The shared parity function used by TX and RX.
- Sub-module uart_baud_timer: reloadable down-counter with load and tick outputs. It is reusable by the future uart_rx.

Test Plan:
- Basic frame: div=3, no parity, 1 stop, push 0xA5.
  - Exactly one fifo_pop pulse.
  - uart_txd, one bit per 4 cycles: 0,1,0,1,0,0,1,0,1,1.
  - busy high for 40 cycles, then uart_txd=1 and busy=0.
- Parity: 0xA5 with parity_en=1.
  - Even: parity bit 0. Odd: parity bit 1.
  - 0x07 even: parity bit 1.
  - Frame is 11 bits; with stop2=1, two high stop periods and 12 bits.
- Back-to-back: div=0, FIFO preloaded with 0x55 and 0x0F.
  - Two pops, 10 cycles apart.
  - Second start bit immediately follows the first stop bit; 20-cycle continuous frame; no idle-high gap.
- Enable gating: cfg_en=0 with a FIFO holding 0x3C.
  - No pop; uart_txd stays 1; g_clk_req=0.
  - Raise cfg_en: frame sent.
  - Drop cfg_en mid-frame: frame completes, second byte not popped.
- Reset mid-frame: div=7, assert g_resetn=0 during DATA.
  - Next cycle: uart_txd=1, busy=0, fifo_pop=0.
  - After release, the next FIFO byte is sent as a full, correct frame.
- Config latching: change cfg_clk_div 3 -> 1 mid-frame.
  - Current frame keeps the 4-cycle bit period.
  - Next frame uses the 2-cycle bit period.
